// File: rtl/gpu_draw_engine.sv
// gpu_draw_engine: executes PLOT / HSPAN / CLEAR commands as palette-index writes into the framebuffer port.
// Define GPU_CLIP_EN to drop off-screen PLOT/HSPAN and truncate spans at the right edge; otherwise addresses wrap linearly.
module gpu_draw_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 19
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic [31:0]        cp_x_i,
  input  logic [31:0]        cp_y_i,
  input  logic [31:0]        index_i,
  input  logic [31:0]        cmd_i,
  output logic               fb_en_o,
  output logic               fb_we_o,
  output logic [ADDR_W-1:0]  fb_addr_o,
  output logic [PIXEL_W-1:0] fb_din_o,
  output logic               busy_o,
  output logic [1:0]         err_o,
  output logic [15:0]        cmd_count_o
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;
  state_t state_q, state_d;
  logic seq_q, seq_d, pend_q, pend_d, we_q, we_d;
  logic [15:0] px_q, px_d, py_q, py_d, plen_q, plen_d;
  logic [15:0] wx_q, wx_d, wy_q, wy_d, wlen_q, wlen_d, cnt_q, cnt_d;
  logic [2:0] pop_q, pop_d, wop_q, wop_d;
  logic [PIXEL_W-1:0] pidx_q, pidx_d, widx_q, widx_d, din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [1:0] err_q, err_d;
  logic tog, calc_err;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] ncnt, wcnt;
  assign tog  = cmd_i[31] ^ seq_q;
  assign base = (wop_q == 3'd3) ? '0 : ADDR_W'(wy_q) * ADDR_W'(H_RES) + ADDR_W'(wx_q);
  assign ncnt = (wop_q == 3'd1) ? CW'(1) :
                (wop_q == 3'd2) ? CW'(wlen_q) :
                (wop_q == 3'd3) ? CW'(H_RES * V_RES) : '0;
`ifdef GPU_CLIP_EN
  localparam logic [16:0] HR = 17'(H_RES);
  localparam logic [16:0] VR = 17'(V_RES);
  logic oob, trunc;
  logic [16:0] room;
  assign oob      = (wop_q == 3'd1 || wop_q == 3'd2) && ({1'b0, wx_q} >= HR || {1'b0, wy_q} >= VR);
  assign room     = HR - {1'b0, wx_q};
  assign trunc    = (wop_q == 3'd2) && !oob && ({1'b0, wlen_q} > room);
  assign wcnt     = oob ? '0 : trunc ? CW'(room) : ncnt;
  assign calc_err = wop_q[2] | oob | trunc;
`else
  assign wcnt     = ncnt;
  assign calc_err = wop_q[2];
`endif
  always_comb begin
    state_d = state_q;
    seq_d   = cmd_i[31];
    pend_d  = pend_q;
    px_d    = px_q;
    py_d    = py_q;
    plen_d  = plen_q;
    pop_d   = pop_q;
    pidx_d  = pidx_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wlen_d  = wlen_q;
    wop_d   = wop_q;
    widx_d  = widx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (tog && pend_q) err_d[0] = 1'b1;
    else if (tog) begin
      pend_d = 1'b1;
      px_d   = cp_x_i[15:0];
      py_d   = cp_y_i[15:0];
      pidx_d = index_i[PIXEL_W-1:0];
      pop_d  = cmd_i[30:28];
      plen_d = cmd_i[15:0];
    end
    case (state_q)
      IDLE: if (pend_q) begin
        pend_d  = 1'b0;
        wx_d    = px_q;
        wy_d    = py_q;
        widx_d  = pidx_q;
        wop_d   = pop_q;
        wlen_d  = plen_q;
        state_d = CALC;
      end
      CALC: begin
        err_d[1] = err_q[1] | calc_err;
        if (wcnt == '0) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = RUN;
          we_d    = 1'b1;
          addr_d  = base;
          din_d   = widx_q;
          rem_d   = wcnt;
        end
      end
      default: if (rem_q == CW'(1)) begin
        state_d = IDLE;
        we_d    = 1'b0;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - CW'(1);
      end
    endcase
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      pend_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      plen_q  <= '0;
      pop_q   <= '0;
      pidx_q  <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      wlen_q  <= '0;
      wop_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rem_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      px_q    <= px_d;
      py_q    <= py_d;
      plen_q  <= plen_d;
      pop_q   <= pop_d;
      pidx_q  <= pidx_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wlen_q  <= wlen_d;
      wop_q   <= wop_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign fb_en_o     = we_q;
  assign fb_we_o     = we_q;
  assign fb_addr_o   = addr_q;
  assign fb_din_o    = din_q;
  assign busy_o      = pend_q | (state_q != IDLE);
  assign err_o       = err_q;
  assign cmd_count_o = cnt_q;
endmodule

// File: tb/tb_gpu_draw_engine.sv
// tb_gpu_draw_engine: directed command sequences with hand-computed framebuffer writes, counters and error flags.
module tb_gpu_draw_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cp_x_i = '0, cp_y_i = '0, index_i = '0, cmd_i = '0;
  logic fb_en_o, fb_we_o, busy_o;
  logic [18:0] fb_addr_o;
  logic [7:0] fb_din_o;
  logic [1:0] err_o;
  logic [15:0] cmd_count_o;
  int n_cmp = 0, n_bad = 0;
  gpu_draw_engine dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cp_x_i(cp_x_i), .cp_y_i(cp_y_i), .index_i(index_i), .cmd_i(cmd_i),
    .fb_en_o(fb_en_o), .fb_we_o(fb_we_o), .fb_addr_o(fb_addr_o), .fb_din_o(fb_din_o),
    .busy_o(busy_o), .err_o(err_o), .cmd_count_o(cmd_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input int x, input int y, input logic [7:0] idx, input logic [2:0] op, input logic [15:0] len);
    cp_x_i  = x;
    cp_y_i  = y;
    index_i = {24'hABCDEF, idx};
    cmd_i   = {~cmd_i[31], op, 12'h0, len};
  endtask
  task automatic span(input string tag, input int a0, input int n, input logic [7:0] d, input int lat, input bit inj, input bit tail);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!fb_we_o && c < 40);
    chk({tag, "_lat"}, c, lat);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (inj && i == 10) issue(5, 5, 8'h22, 3'd1, 16'd0);
      if (inj && i == 11) issue(7, 7, 8'h33, 3'd1, 16'd0);
      chk({tag, "_we"}, {fb_en_o, fb_we_o}, 2'b11);
      chk({tag, "_addr"}, fb_addr_o, (a0 + i) % 524288);
      chk({tag, "_din"}, fb_din_o, d);
    end
    if (tail) begin
      @(negedge clk);
      chk({tag, "_end"}, fb_we_o, 0);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_we", {fb_en_o, fb_we_o}, 0);
    chk("rst_addr", fb_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", cmd_count_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3, 2, 8'h5A, 3'd1, 16'd0);
    chk("plot_cmd", cmd_i, 32'h9000_0000);
    span("plot", 1283, 1, 8'h5A, 3, 0, 1);
    chk("plot_cnt", cmd_count_o, 1);
    chk("plot_busy", busy_o, 0);
    issue(10, 0, 8'hC3, 3'd2, 16'd4);
    @(negedge clk);
    chk("hs4_busy", busy_o, 1);
    span("hs4", 10, 4, 8'hC3, 2, 0, 1);
    chk("hs4_cnt", cmd_count_o, 2);
    issue(0, 1, 8'h11, 3'd2, 16'd100);
    span("hs100", 640, 100, 8'h11, 3, 1, 1);
    chk("ovr_err", err_o, 2'b01);
    span("queued", 3205, 1, 8'h22, 2, 0, 1);
    chk("queued_cnt", cmd_count_o, 4);
    chk("queued_busy", busy_o, 0);
    issue(638, 0, 8'h44, 3'd2, 16'd5);
`ifdef GPU_CLIP_EN
    span("clip", 638, 2, 8'h44, 3, 0, 1);
    chk("clip_err", err_o[1], 1);
`else
    span("wrap", 638, 5, 8'h44, 3, 0, 1);
    chk("wrap_err", err_o[1], 0);
`endif
    chk("edge_cnt", cmd_count_o, 5);
    issue(0, 0, 8'h00, 3'd6, 16'd0);
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (fb_we_o) w++;
    end
    chk("op6_writes", w, 0);
    chk("op6_cnt", cmd_count_o, 6);
    chk("op6_err", err_o[1], 1);
    issue(20, 20, 8'h99, 3'd2, 16'd0);
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (fb_we_o) w++;
    end
    chk("len0_writes", w, 0);
    chk("len0_cnt", cmd_count_o, 7);
    issue(0, 0, 8'h77, 3'd3, 16'd0);
    span("clr", 0, 200, 8'h77, 3, 0, 0);
    #2 rst_n = 1'b0;
    cmd_i = '0;
    #1;
    chk("arst_we", {fb_en_o, fb_we_o}, 0);
    chk("arst_addr", fb_addr_o, 0);
    chk("arst_din", fb_din_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_cnt", cmd_count_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, 0, 8'h0F, 3'd1, 16'd0);
    span("post", 1, 1, 8'h0F, 3, 0, 1);
    chk("post_cnt", cmd_count_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
